// File: rtl/booth_pkg.sv
// Shared radix-8 Booth digit encodings, used by the recoder and the downstream
// partial-product selector.
package booth_pkg;

  localparam int BOOTH_N_BITS = 24;

  // [4] = negate, [3:0] = one-hot magnitude (1X, 2X, 3X, 4X)
  typedef logic [4:0] booth_enc_t;

  localparam booth_enc_t ENC_ZERO = 5'b00000;
  localparam booth_enc_t ENC_P1   = 5'b00001;
  localparam booth_enc_t ENC_P2   = 5'b00010;
  localparam booth_enc_t ENC_P3   = 5'b00100;
  localparam booth_enc_t ENC_P4   = 5'b01000;
  localparam booth_enc_t ENC_N1   = 5'b10001;
  localparam booth_enc_t ENC_N2   = 5'b10010;
  localparam booth_enc_t ENC_N3   = 5'b10100;
  localparam booth_enc_t ENC_N4   = 5'b11000;

endpackage

// File: rtl/booth_r8_enc.sv
// Radix-8 Booth digit recoder: maps a 4-bit window {b2,b1,b0,b-1} to the
// signed digit -4*b2 + 2*b1 + b0 + b-1.
module booth_r8_enc
  import booth_pkg::*;
(
  input  logic [3:0] grp,
  output booth_enc_t enc
);

  // Window-to-digit table; zero is encoded with a clear sign bit.
  always_comb begin
    enc = ENC_ZERO;
    case (grp)
      4'b0000, 4'b1111: enc = ENC_ZERO;
      4'b0001, 4'b0010: enc = ENC_P1;
      4'b0011, 4'b0100: enc = ENC_P2;
      4'b0101, 4'b0110: enc = ENC_P3;
      4'b0111:          enc = ENC_P4;
      4'b1000:          enc = ENC_N4;
      4'b1001, 4'b1010: enc = ENC_N3;
      4'b1011, 4'b1100: enc = ENC_N2;
      4'b1101, 4'b1110: enc = ENC_N1;
      default:          enc = ENC_ZERO;
    endcase
  end

endmodule

// File: rtl/booth_encoder_seq.sv
// Sequential radix-8 Booth recoder: accepts an unsigned multiplier and streams
// one signed digit per downstream handshake, least significant group first.
module booth_encoder_seq
  import booth_pkg::*;
#(
  parameter int N_BITS = BOOTH_N_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_enc,
  output logic [3:0]        out_idx,
  output logic              out_last
);

  localparam int         N_GROUPS = (N_BITS + 1 + 2) / 3;
  localparam int         SR_W     = N_BITS + 4;
  localparam logic [3:0] LAST_IDX = 4'(N_GROUPS - 1);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] BUSY     = 1'b1;

  logic [0:0]      state_r, state_nxt_s;
  logic [SR_W-1:0] sr_r, sr_nxt_s;
  logic [3:0]      idx_r, idx_nxt_s;
  logic            busy_s, last_s, fire_s, accept_s;
  booth_enc_t      enc_s;

  booth_r8_enc u_enc (
    .grp (sr_r[3:0]),
    .enc (enc_s)
  );

  assign busy_s   = (state_r == BUSY);
  assign last_s   = busy_s && (idx_r == LAST_IDX);
  assign fire_s   = busy_s && out_ready;
  // Final handshake frees the slot in the same cycle for zero-bubble reloads.
  assign in_ready = !busy_s || (out_ready && last_s);
  assign accept_s = in_valid && in_ready;

  assign out_valid = busy_s;
  assign out_enc   = enc_s;
  assign out_idx   = idx_r;
  assign out_last  = last_s;

  // Next-state: load on accept, shift one group per handshake, clear on exit.
  always_comb begin
    state_nxt_s = state_r;
    sr_nxt_s    = sr_r;
    idx_nxt_s   = idx_r;
    if (accept_s) begin
      state_nxt_s = BUSY;
      sr_nxt_s    = {3'b000, in_y, 1'b0};
      idx_nxt_s   = 4'd0;
    end else if (fire_s && last_s) begin
      state_nxt_s = IDLE;
      sr_nxt_s    = {SR_W{1'b0}};
      idx_nxt_s   = 4'd0;
    end else if (fire_s) begin
      sr_nxt_s    = {3'b000, sr_r[SR_W-1:3]};
      idx_nxt_s   = idx_r + 4'd1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State registers; reset empties the shift register so nothing stale leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sr_r    <= {SR_W{1'b0}};
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      sr_r    <= sr_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

endmodule

// File: tb/tb_booth_encoder_seq.sv
// Directed and randomized self-check of the sequential radix-8 Booth recoder.
module tb_booth_encoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_y = 24'h000000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_enc;
  logic [3:0]  out_idx;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  logic [4:0] e_zero [9];
  logic [4:0] e_seven [9];
  logic [4:0] e_ones [9];
  logic [4:0] e_mix [9];

  booth_encoder_seq #(.N_BITS(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_enc   (out_enc),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_group(input int g, input logic [4:0] e, input logic rdy);
    chk("valid", 32'(out_valid), 32'd1);
    chk("idx",   32'(out_idx),   32'(g));
    chk("enc",   32'(out_enc),   32'(e));
    chk("last",  32'(out_last),  32'(g == 8));
    chk("in_rdy_busy", 32'(in_ready), 32'(rdy));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready),  32'd1);
    chk({tag, "_enc"},   32'(out_enc),   32'd0);
    chk({tag, "_idx"},   32'(out_idx),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  task automatic load(input logic [23:0] y);
    in_valid = 1'b1;
    in_y     = y;
    #1;
    chk("accept_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_y     = 24'($urandom());
  endtask

  // Walks all nine groups; optionally stalls at one index and chains a next operand.
  task automatic stream(input logic [4:0] e [9], input int stall_idx,
                        input logic nxt_v, input logic [23:0] nxt_y);
    for (int g = 0; g < 9; g++) begin
      if (g == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          check_group(g, e[g], 1'b0);
          in_y = 24'($urandom());
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (g == 8 && nxt_v) begin
        in_valid = 1'b1;
        in_y     = nxt_y;
      end
      #1;
      check_group(g, e[g], g == 8);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (!nxt_v) begin
      chk("end_valid", 32'(out_valid), 32'd0);
      chk("end_rdy",   32'(in_ready),  32'd1);
    end
  endtask

  function automatic int dec(input logic [4:0] e);
    int m;
    case (e[3:0])
      4'b0000: m = 0;
      4'b0001: m = 1;
      4'b0010: m = 2;
      4'b0100: m = 3;
      4'b1000: m = 4;
      default: m = 999;
    endcase
    if (e == 5'b10000) m = 999;
    else if (e[4]) m = -m;
    return m;
  endfunction

  initial begin
    logic [23:0] y;
    longint      acc;
    int          hs;
    int          cyc;
    logic        order_ok;

    e_zero  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                5'b00000, 5'b00000, 5'b00000, 5'b00000};
    e_seven = '{5'b10001, 5'b00001, 5'b00000, 5'b00000, 5'b00000,
                5'b00000, 5'b00000, 5'b00000, 5'b00000};
    e_ones  = '{5'b10001, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                5'b00000, 5'b00000, 5'b00000, 5'b00001};
    // 0x287D63: digits +3 -4 -2 -1 0 +1 +2 +1 0
    e_mix   = '{5'b00100, 5'b11000, 5'b10010, 5'b10001, 5'b00000,
                5'b00001, 5'b00010, 5'b00001, 5'b00000};

    #12;
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    load(24'h000000);
    stream(e_zero, -1, 1'b0, 24'h000000);

    load(24'h000007);
    stream(e_seven, -1, 1'b0, 24'h000000);

    load(24'hFFFFFF);
    stream(e_ones, -1, 1'b0, 24'h000000);

    load(24'h287D63);
    stream(e_mix, -1, 1'b0, 24'h000000);

    load(24'h287D63);
    stream(e_mix, 3, 1'b0, 24'h000000);

    load(24'h000007);
    stream(e_seven, -1, 1'b1, 24'hFFFFFF);
    stream(e_ones, -1, 1'b0, 24'h000000);

    // Reset mid-operand at idx 4, then a clean restart.
    load(24'h287D63);
    for (int g = 0; g < 4; g++) begin
      #1;
      check_group(g, e_mix[g], 1'b0);
      @(posedge clk); #1;
    end
    #1;
    chk("pre_rst_idx", 32'(out_idx), 32'd4);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    load(24'h000007);
    stream(e_seven, -1, 1'b0, 24'h000000);

    // Random operands with random downstream backpressure; digit sum must equal y.
    for (int n = 0; n < 3000; n++) begin
      y = 24'($urandom());
      load(y);
      acc      = 0;
      hs       = 0;
      cyc      = 0;
      order_ok = 1'b1;
      while (hs < 9 && cyc < 200) begin
        out_ready = ($urandom_range(0, 4) != 0);
        #1;
        if (out_valid && out_ready) begin
          if (out_idx != 4'(hs)) order_ok = 1'b0;
          acc += longint'(dec(out_enc)) * (longint'(1) << (3 * hs));
          hs++;
        end
        @(posedge clk); #1;
        cyc++;
      end
      out_ready = 1'b1;
      #1;
      chk("rnd_count", 32'(hs), 32'd9);
      chk("rnd_sum",   acc[31:0], {8'h00, y});
      chk("rnd_order", 32'(order_ok), 32'd1);
      chk("rnd_idle",  32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
